// File: rtl/pwm_pkg.sv
// Shared types and default constants for the breathing-LED PWM controller.
package pwm_pkg;

   typedef enum logic {
      MANUAL = 1'b0,
      AUTO   = 1'b1
   } mode_t;

   localparam int DEF_WIDTH    = 11;
   localparam int DEF_NCH      = 4;
   localparam int DEF_STEP_W   = 4;
   localparam int DEF_PRESCALE = 1048576;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: triangle-stepping brightness level, period-aligned duty
// reload and the registered comparator output.
module pwm_chan
   import pwm_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STEP_W = DEF_STEP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step_en,
   input  logic              period_end,
   input  logic [WIDTH-1:0]  pwm_cnt,
   output logic              pwm_sig,
   output logic [STEP_W-1:0] level
);

   localparam logic [STEP_W-1:0] LVL_MAX = '1;

   logic             dwn;
   logic [WIDTH-1:0] duty_act;
   logic [WIDTH-1:0] target;

   // Level occupies the top STEP_W bits of the duty word.
   assign target = WIDTH'(level) << (WIDTH - STEP_W);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level    <= '0;
         dwn      <= 1'b0;
         duty_act <= '0;
         pwm_sig  <= 1'b0;
      end else begin
         // Turning around at an endpoint moves one step away so the endpoint
         // is never repeated.
         if (step_en) begin
            if (!dwn) begin
               if (level != LVL_MAX) begin
                  level <= level + 1'b1;
               end else begin
                  level <= LVL_MAX - 1'b1;
                  dwn   <= 1'b1;
               end
            end else begin
               if (level != '0) begin
                  level <= level - 1'b1;
               end else begin
                  level <= STEP_W'(1);
                  dwn   <= 1'b0;
               end
            end
         end
         if (period_end) begin
            duty_act <= target;
         end
         // NOTE: non-blocking, so this compare uses the duty_act held before
         // this edge; a reload at the period end only shows from pwm_cnt=0.
         pwm_sig <= (pwm_cnt < duty_act);
      end
   end

endmodule

// File: rtl/pwm_breathe_ctrl.sv
// Multi-channel breathing PWM controller: shared period counter, MANUAL/AUTO
// mode machine, auto-ramp prescaler and channel selector.
module pwm_breathe_ctrl
   import pwm_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int NCH      = DEF_NCH,
   parameter int STEP_W   = DEF_STEP_W,
   parameter int PRESCALE = DEF_PRESCALE,
   localparam int SEL_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step,
   input  logic              mode_tgl,
   input  logic              sel_nxt,
   output logic [NCH-1:0]    pwm_sig,
   output logic [SEL_W-1:0]  sel_ch,
   output logic [STEP_W-1:0] sel_level,
   output logic              auto_mode
);

   localparam int               PRE_W    = $clog2(PRESCALE);
   localparam logic [WIDTH-1:0] CNT_LAST = '1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NCH - 1);

   mode_t             state;
   logic [WIDTH-1:0]  pwm_cnt;
   logic [PRE_W-1:0]  presc;
   logic              auto_tick;
   logic              period_end;
   logic [NCH-1:0]    step_en;
   logic [STEP_W-1:0] level [NCH];

   assign auto_tick  = (state == AUTO) && (presc == PRE_LAST);
   assign period_end = (pwm_cnt == CNT_LAST);
   assign auto_mode  = (state == AUTO);
   assign sel_level  = level[sel_ch];

   // A coincident mode_tgl discards a manual step; auto ticks hit all channels.
   always_comb begin
      // NOTE: default first so every path assigns step_en and no latch forms.
      step_en = '0;
      if (auto_tick) begin
         step_en = '1;
      end else if ((state == MANUAL) && step && !mode_tgl) begin
         step_en[sel_ch] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= MANUAL;
         pwm_cnt <= '0;
         presc   <= '0;
         sel_ch  <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         if (mode_tgl) begin
            state <= (state == MANUAL) ? AUTO : MANUAL;
         end
         // Held at zero outside AUTO, so every AUTO entry starts a full count.
         if (state != AUTO) begin
            presc <= '0;
         end else begin
            presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
         end
         if (sel_nxt) begin
            sel_ch <= (sel_ch == SEL_LAST) ? '0 : sel_ch + 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      pwm_chan #(
         .WIDTH  (WIDTH),
         .STEP_W (STEP_W)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .step_en    (step_en[i]),
         .period_end (period_end),
         .pwm_cnt    (pwm_cnt),
         .pwm_sig    (pwm_sig[i]),
         .level      (level[i])
      );
   end

endmodule

// File: tb/tb_pwm_breathe_ctrl.sv
// Directed self-checking bench for pwm_breathe_ctrl (WIDTH=11, NCH=4,
// STEP_W=4, PRESCALE=8).
module tb_pwm_breathe_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       step = 1'b0;
   logic       mode_tgl = 1'b0;
   logic       sel_nxt = 1'b0;
   logic [3:0] pwm_sig;
   logic [1:0] sel_ch;
   logic [3:0] sel_level;
   logic       auto_mode;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int t0 = 0;
   int high_cnt;
   int other_cnt;

   // Reference period counter, expected to track the DUT's pwm_cnt.
   logic [10:0] mcnt;

   pwm_breathe_ctrl #(
      .WIDTH    (11),
      .NCH      (4),
      .STEP_W   (4),
      .PRESCALE (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .step      (step),
      .mode_tgl  (mode_tgl),
      .sel_nxt   (sel_nxt),
      .pwm_sig   (pwm_sig),
      .sel_ch    (sel_ch),
      .sel_level (sel_level),
      .auto_mode (auto_mode)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) mcnt <= '0;
      else     mcnt <= mcnt + 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic tick_to(input int k);
      int guard = 0;
      while ((cyc - t0) < k && guard < 1000) begin
         tick();
         guard++;
      end
   endtask

   // Advance until the model counter reads c; pwm_sig then reflects count c-1.
   task automatic wait_cnt(input int c);
      int n = 0;
      do begin
         tick();
         n++;
      end while (int'(mcnt) != c && n < 5000);
      if (int'(mcnt) != c) begin
         failures++;
         $display("FAIL wait_cnt timeout: got %0d expected %0d", mcnt, c);
      end
   endtask

   task automatic pulse_step();
      step = 1'b1;
      tick();
      step = 1'b0;
   endtask

   task automatic pulse_sel();
      sel_nxt = 1'b1;
      tick();
      sel_nxt = 1'b0;
   endtask

   task automatic pulse_mode();
      mode_tgl = 1'b1;
      tick();
      mode_tgl = 1'b0;
   endtask

   int down_seq [17] = '{13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3};

   initial begin
      // Reset state
      #12;
      check("rst_pwm", pwm_sig, 0);
      check("rst_sel", sel_ch, 0);
      check("rst_lvl", sel_level, 0);
      check("rst_auto", auto_mode, 0);
      rst = 1'b0;
      tick();
      tick();
      check("post_rst_pwm", pwm_sig, 0);

      // Ramp channel 0 to full level
      for (int i = 1; i <= 15; i++) begin
         pulse_step();
         check($sformatf("up_%0d", i), sel_level, i);
      end
      wait_cnt(1);
      wait_cnt(1);
      high_cnt = 0;
      other_cnt = 0;
      for (int i = 0; i < 2048; i++) begin
         if (pwm_sig[0]) high_cnt++;
         if (pwm_sig[3:1] != 3'b000) other_cnt++;
         tick();
      end
      check("ch0_high_cnt", high_cnt, 1920);
      check("ch321_high_cnt", other_cnt, 0);

      // Mid-period step: 15 -> 14 must not alter the running period
      wait_cnt(500);
      pulse_step();
      check("mid_step_lvl", sel_level, 14);
      wait_cnt(1851);
      check("old_duty_1850", pwm_sig[0], 1);
      wait_cnt(1920);
      check("old_duty_1919", pwm_sig[0], 1);
      wait_cnt(1792);
      check("new_duty_1791", pwm_sig[0], 1);
      wait_cnt(1851);
      check("new_duty_1850", pwm_sig[0], 0);

      // Descend to 0, turn around, keep climbing
      for (int i = 0; i < 17; i++) begin
         pulse_step();
         check($sformatf("down_%0d", i), sel_level, down_seq[i]);
      end

      // sel_nxt with step: step lands on the old channel (ch0 -> 4)
      sel_nxt = 1'b1;
      step = 1'b1;
      tick();
      sel_nxt = 1'b0;
      step = 1'b0;
      check("sel_step_ch", sel_ch, 1);
      check("sel_step_ch1_lvl", sel_level, 0);
      pulse_sel();
      pulse_sel();
      pulse_sel();
      check("sel_wrap_ch", sel_ch, 0);
      check("sel_wrap_lvl", sel_level, 4);

      // AUTO: all channels step together every 8 clocks
      pulse_mode();
      t0 = cyc;
      check("auto_on", auto_mode, 1);
      tick_to(7);
      check("auto_k7", sel_level, 4);
      tick_to(8);
      check("auto_k8", sel_level, 5);
      pulse_step();
      check("auto_step_ign", sel_level, 5);
      tick_to(15);
      check("auto_k15", sel_level, 5);
      tick_to(16);
      check("auto_k16", sel_level, 6);
      pulse_sel();
      check("auto_ch1", sel_level, 2);
      pulse_sel();
      check("auto_ch2", sel_level, 2);
      pulse_sel();
      check("auto_ch3", sel_level, 2);
      tick_to(24);
      check("auto_ch3_k24", sel_level, 3);
      pulse_sel();
      check("auto_sel_wrap", sel_ch, 0);
      check("auto_ch0_k25", sel_level, 7);
      pulse_mode();
      check("manual_back", auto_mode, 0);
      check("manual_lvl", sel_level, 7);

      // mode_tgl with step in MANUAL: AUTO entered, step discarded
      wait_cnt(2040);
      mode_tgl = 1'b1;
      step = 1'b1;
      tick();
      mode_tgl = 1'b0;
      step = 1'b0;
      t0 = cyc;
      check("tgl_step_auto", auto_mode, 1);
      check("tgl_step_lvl", sel_level, 7);
      tick_to(7);
      check("reentry_k7", sel_level, 7);
      tick_to(8);
      check("reentry_k8", sel_level, 8);
      tick_to(10);
      check("pre_rst_pwm", pwm_sig, 4'hF);

      // Asynchronous reset mid-period in AUTO
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_pwm", pwm_sig, 0);
      check("async_rst_auto", auto_mode, 0);
      check("async_rst_sel", sel_ch, 0);
      check("async_rst_lvl", sel_level, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      check("after_rst_pwm", pwm_sig, 0);
      check("after_rst_auto", auto_mode, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pwm_breathe_ctrl.md
PWM_BREATHE_CTRL -- requirements
Module: pwm_breathe_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 11: PWM counter and duty resolution in bits.
REQ-002 The block SHALL have parameter NCH, default 4: number of independent PWM channels.
REQ-003 The block SHALL have parameter STEP_W, default 4: per-channel brightness level width, legal range 1..WIDTH.
REQ-004 The block SHALL have parameter PRESCALE, default 1048576: clocks between auto-ramp steps, minimum 2.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port step, input, 1 bit: single-cycle pulse that advances the selected channel's level in MANUAL mode.
REQ-008 The block SHALL have port mode_tgl, input, 1 bit: single-cycle pulse that toggles between MANUAL and AUTO.
REQ-009 The block SHALL have port sel_nxt, input, 1 bit: single-cycle pulse that advances the selected channel.
REQ-010 The block SHALL have port pwm_sig, output, NCH bits: per-channel PWM outputs, registered.
REQ-011 The block SHALL have port sel_ch, output, $clog2(NCH) bits (minimum 1): index of the selected channel.
REQ-012 The block SHALL have port sel_level, output, STEP_W bits: current level of the selected channel, for LED observability.
REQ-013 The block SHALL have port auto_mode, output, 1 bit: 1 when the state is AUTO.

Function
REQ-014 A free-running WIDTH-bit counter pwm_cnt SHALL increment every clock and wrap from 2^WIDTH-1 to 0.
REQ-015 Each channel i SHALL hold level[i] (STEP_W bits) and a direction flag dwn[i]; its target duty SHALL be {level[i], (WIDTH-STEP_W) zeros}.
REQ-016 Each channel SHALL copy target duty into duty_act[i] only in the cycle pwm_cnt==2^WIDTH-1, so a duty change never alters a period already in progress.
REQ-017 The block SHALL register pwm_sig[i] <= (pwm_cnt < duty_act[i]) every clock (one-cycle latency); level 0 therefore gives a constant 0.
REQ-018 A step event on channel i SHALL update it as follows: dwn=0 and level<max -> level+1; dwn=0 and level==max -> level=max-1, dwn=1; dwn=1 and level>0 -> level-1; dwn=1 and level==0 -> level=1, dwn=0.
REQ-019 The step rule in REQ-018 SHALL produce the triangle sequence 0,1..max,max-1..0,1 with no repeated endpoint.
REQ-020 The state machine SHALL have two states, MANUAL and AUTO; a mode_tgl pulse SHALL swap the state at the next clock.
REQ-021 In MANUAL, a step pulse SHALL apply a step event to channel sel_ch only.
REQ-022 In AUTO, step SHALL be ignored; a prescaler SHALL count 0..PRESCALE-1 and, on its terminal count, apply a step event to all channels in the same cycle.
REQ-023 The prescaler SHALL be cleared on every entry to AUTO, so the first auto step occurs exactly PRESCALE clocks after the transition.
REQ-024 A sel_nxt pulse SHALL increment sel_ch, wrapping from NCH-1 to 0; sel_nxt SHALL be legal in either mode.
REQ-025 If mode_tgl and step coincide, the mode change SHALL take effect and step SHALL be discarded.
REQ-026 If sel_nxt and step coincide in MANUAL, step SHALL apply to the old sel_ch.
REQ-027 sel_level SHALL equal level[sel_ch] combinationally.

Reset
REQ-028 While rst=1, the block SHALL asynchronously clear pwm_cnt, the prescaler, all level, dwn and duty_act registers, pwm_sig, and sel_ch to 0, and set the state to MANUAL.
REQ-029 After rst deasserts, the first PWM period SHALL begin at pwm_cnt=0 with all outputs low; a reset asserted mid-period SHALL abandon that period immediately.

Structure
REQ-030 Package pwm_pkg SHALL hold the mode_t enum (MANUAL, AUTO) and the default parameter constants.
REQ-031 A sub-module pwm_chan (level/dwn step logic, duty_act latch, comparator flop) SHALL be instantiated NCH times in a generate loop; the top SHALL own pwm_cnt, the prescaler, the FSM and the selector.

Verification
REQ-032 Use WIDTH=11, NCH=4, STEP_W=4, PRESCALE=8: reset, then 15 step pulses -> level[0]=15, duty 0x780, pwm_sig[0] high for 1920 of 2048 clocks; pwm_sig[3:1]=0.
REQ-033 From level 15, 16 more step pulses -> levels 14..0 then 1, with dwn=0 after level 0 turns around.
REQ-034 Step mid-period at pwm_cnt=500 -> the current period keeps the old duty, and the new duty is first visible at pwm_cnt=0 plus one clock.
REQ-035 Pulse mode_tgl -> auto_mode=1; all four levels increment together every 8 clocks; a step pulse in AUTO has no effect.
REQ-036 Send mode_tgl and step in the same cycle in MANUAL -> AUTO entered and level unchanged; send sel_nxt 4 times -> sel_ch returns to 0.
REQ-037 Assert rst for 1 clock while pwm_sig=1 and AUTO -> all outputs 0, MANUAL, sel_ch=0 immediately, without waiting for a clock edge.
